// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch target buffer.
// Holds entry layout, table geometry and half-select encodings.
package bp_pkg;

    localparam int BP_ADDR_W  = 16;
    localparam int BP_IDX_W   = 3;
    localparam int BP_HALF_SZ = 4;
    localparam int BP_ENTRIES = 2 * BP_HALF_SZ;
    localparam int BP_CNT_W   = $clog2(BP_HALF_SZ);

    localparam logic BP_HALF_BEQ = 1'b0;
    localparam logic BP_HALF_JAL = 1'b1;

    typedef struct packed {
        logic                 valid;
        logic [BP_ADDR_W-1:0] tag;
        logic [BP_ADDR_W-1:0] target;
        logic                 hist;
    } bp_entry_t;

    // Entry index the controller forms from a half select and that half's victim pointer.
    function automatic logic [BP_IDX_W-1:0] bp_victim_index(input logic half,
                                                            input logic [BP_CNT_W-1:0] cnt);
        return {half, cnt};
    endfunction

endpackage

// File: rtl/bp_rr_counter.sv
// Round-robin victim pointer for one half of the branch target buffer.
// Advances by one on each enabled edge and wraps naturally at its width.
module bp_rr_counter
    import bp_pkg::*;
#(
    parameter int W = BP_CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Eight-entry flop-based branch target buffer with zero-latency lookup.
// Lower half serves BEQ entries, upper half JAL entries, each with its own victim pointer.
module branch_predictor_table
    import bp_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BP_ADDR_W-1:0] PC_in,
    input  logic                 BP_write_enable,
    input  logic [BP_ADDR_W-1:0] PC_BP_in,
    input  logic [BP_ADDR_W-1:0] BTA_BP_in,
    input  logic                 H_BP_in,
    input  logic [BP_IDX_W-1:0]  add_BP_in,
    input  logic                 enable1,
    input  logic                 enable2,
    output logic [BP_IDX_W:0]    add_BP_out,
    output logic [BP_ADDR_W-1:0] BTA_out,
    output logic                 predict_taken,
    output logic [BP_CNT_W-1:0]  count1,
    output logic [BP_CNT_W-1:0]  count2
);

    bp_entry_t             table_q [BP_ENTRIES];
    logic                  hit;
    logic [BP_IDX_W-1:0]   hit_idx;
    bp_entry_t             hit_entry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (BP_write_enable) begin
            table_q[add_BP_in] <= '{valid: 1'b1, tag: PC_BP_in, target: BTA_BP_in, hist: H_BP_in};
        end
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = BP_ENTRIES - 1; i >= 0; i--) begin
            if (table_q[i].valid && (table_q[i].tag == PC_in)) begin
                hit     = 1'b1;
                hit_idx = BP_IDX_W'(i);
            end
        end
    end

    assign hit_entry     = table_q[hit_idx];
    assign add_BP_out    = {hit, hit_idx};
    assign predict_taken = hit & hit_entry.hist;
    assign BTA_out       = predict_taken ? hit_entry.target : PC_in + 1'b1;

    bp_rr_counter #(.W(BP_CNT_W)) u_count_beq (
        .clock  (clock),
        .reset  (reset),
        .enable (enable1),
        .count  (count1)
    );

    bp_rr_counter #(.W(BP_CNT_W)) u_count_jal (
        .clock  (clock),
        .reset  (reset),
        .enable (enable2),
        .count  (count2)
    );

endmodule
